// File: rtl/mul_accumulate_pipelined_if.sv
// Element/result bundle for the pipelined multiply-accumulate stage.
// The producer drives operands and framing; the consumer reads the group result strobe.
interface mul_accumulate_pipelined_if #(
    parameter int unsigned n     = 8,
    parameter int unsigned acc_w = 2 * n + 4
);
    logic             arg_vld;
    logic [n-1:0]     a;
    logic [n-1:0]     b;
    logic             signed_mul;
    logic             first;
    logic             last;
    logic             res_vld;
    logic [acc_w-1:0] res;
    logic             ovf;

    modport master (
        output arg_vld, a, b, signed_mul, first, last,
        input  res_vld, res, ovf
    );

    modport slave (
        input  arg_vld, a, b, signed_mul, first, last,
        output res_vld, res, ovf
    );
endinterface

// File: rtl/mul_accumulate_pipelined.sv
// Three-stage multiply-accumulate: operand register, product register, accumulator/result.
// Groups are framed by first/last; each group emits one sum with a sticky overflow flag.
module mul_accumulate_pipelined #(
    parameter int unsigned n     = 8,
    parameter int unsigned acc_w = 2 * n + 4
) (
    input logic                       clk,
    input logic                       rst,
    mul_accumulate_pipelined_if.slave bus
);

    typedef logic [acc_w-1:0] acc_t;
    typedef logic [2*n-1:0]   prod_t;

    // Stage 1: operand capture
    logic         s1_vld_q;
    logic [n-1:0] s1_a_q;
    logic [n-1:0] s1_b_q;
    logic         s1_signed_q;
    logic         s1_first_q;
    logic         s1_last_q;

    // Stage 2: full-width product
    logic         s2_vld_q;
    prod_t        s2_prod_q;
    logic         s2_signed_q;
    logic         s2_first_q;
    logic         s2_last_q;
    prod_t        prod_d;

    // Stage 3: accumulator and result
    acc_t         acc_q;
    logic         ovf_acc_q;
    logic         res_vld_q;
    acc_t         res_q;
    logic         ovf_q;

    acc_t         ext;
    acc_t         base;
    logic [acc_w:0] sum_wide;
    acc_t         sum;
    logic         elem_ovf;
    logic         ovf_acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_signed_q <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
        end else begin
            s1_vld_q <= bus.arg_vld;
            if (bus.arg_vld) begin
                s1_a_q      <= bus.a;
                s1_b_q      <= bus.b;
                s1_signed_q <= bus.signed_mul;
                s1_first_q  <= bus.first;
                s1_last_q   <= bus.last;
            end
        end
    end

    // Operands are widened to 2n before multiplying, so -2^(n-1) squared stays exact.
    always_comb begin
        prod_d = '0;
        if (s1_signed_q) begin
            prod_d = prod_t'($signed({{n{s1_a_q[n-1]}}, s1_a_q}) *
                             $signed({{n{s1_b_q[n-1]}}, s1_b_q}));
        end else begin
            prod_d = prod_t'({{n{1'b0}}, s1_a_q} * {{n{1'b0}}, s1_b_q});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q    <= 1'b0;
            s2_prod_q   <= '0;
            s2_signed_q <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_prod_q   <= prod_d;
                s2_signed_q <= s1_signed_q;
                s2_first_q  <= s1_first_q;
                s2_last_q   <= s1_last_q;
            end
        end
    end

    always_comb begin
        ext       = '0;
        base      = '0;
        sum_wide  = '0;
        sum       = '0;
        elem_ovf  = 1'b0;
        ovf_acc_d = ovf_acc_q;

        if (s2_signed_q) begin
            ext = acc_t'($signed(s2_prod_q));
        end else begin
            ext = acc_t'(s2_prod_q);
        end

        base     = s2_first_q ? '0 : acc_q;
        sum_wide = {1'b0, base} + {1'b0, ext};
        sum      = sum_wide[acc_w-1:0];

        // Overflow rule follows the element's own mode, even inside a mixed group.
        if (s2_signed_q) begin
            elem_ovf = (base[acc_w-1] == ext[acc_w-1]) && (sum[acc_w-1] != ext[acc_w-1]);
        end else begin
            elem_ovf = sum_wide[acc_w];
        end

        ovf_acc_d = s2_first_q ? elem_ovf : (ovf_acc_q | elem_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            res_vld_q <= 1'b0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            res_vld_q <= s2_vld_q & s2_last_q;
            if (s2_vld_q) begin
                acc_q     <= sum;
                ovf_acc_q <= ovf_acc_d;
                if (s2_last_q) begin
                    res_q <= sum;
                    ovf_q <= ovf_acc_d;
                end
            end
        end
    end

    assign bus.res_vld = res_vld_q;
    assign bus.res     = res_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_mul_accumulate_pipelined.sv
// Scoreboard bench: stimulus pushes hand-computed group results with their due cycle,
// a negedge monitor pops and compares whenever res_vld is seen.
module tb_mul_accumulate_pipelined;

    localparam int unsigned N    = 4;
    localparam int unsigned AccW = 12;

    typedef struct {
        logic [AccW-1:0] res;
        logic            ovf;
        int              cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    mul_accumulate_pipelined_if #(.n(N), .acc_w(AccW)) bus ();

    mul_accumulate_pipelined #(
        .n     (N),
        .acc_w (AccW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
        end
    endtask

    // Result for an element sampled at the coming edge is visible three negedges from now.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic sm,
                        input logic f, input logic l, input logic expect_res,
                        input logic [AccW-1:0] eres, input logic eovf);
        exp_t e;
        @(negedge clk);
        bus.arg_vld    = 1'b1;
        bus.a          = a;
        bus.b          = b;
        bus.signed_mul = sm;
        bus.first      = f;
        bus.last       = l;
        if (expect_res) begin
            e.res = eres;
            e.ovf = eovf;
            e.cyc = cyc + 3;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            bus.arg_vld    = 1'b0;
            bus.a          = 4'hA;
            bus.b          = 4'h5;
            bus.signed_mul = 1'b1;
            bus.first      = 1'b1;
            bus.last       = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.res_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_res_vld: got res=%0d ovf=%0b at cycle %0d, required none",
                         bus.res, bus.ovf, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("res", int'(bus.res), int'(e.res));
                chk("ovf", int'(bus.ovf), int'(e.ovf));
                chk("res_vld_cycle", cyc, e.cyc);
            end
        end else if (bus.res_vld !== 1'b0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL res_vld_unknown: got %b, required 0 or 1 (cycle %0d)", bus.res_vld, cyc);
        end
    end

    initial begin
        rst            = 1'b1;
        bus.arg_vld    = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.signed_mul = 1'b0;
        bus.first      = 1'b0;
        bus.last       = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_res_vld", int'(bus.res_vld), 0);
        chk("reset_res", int'(bus.res), 0);
        chk("reset_ovf", int'(bus.ovf), 0);

        // Unsigned single-element group
        send(4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 12'd225, 1'b0);
        idle(4);

        // Signed group with bubbles: 64 - 56 - 6 = 2
        send(4'h8, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        idle(2);
        send(4'h8, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
        idle(2);
        send(4'h3, 4'hE, 1'b1, 1'b0, 1'b1, 1'b1, 12'd2, 1'b0);
        idle(3);

        // Same group without bubbles
        send(4'h8, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        send(4'h8, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
        send(4'h3, 4'hE, 1'b1, 1'b0, 1'b1, 1'b1, 12'd2, 1'b0);
        idle(3);

        // Back-to-back single-element groups
        send(4'h1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1, 12'd1, 1'b0);
        send(4'h2, 4'h2, 1'b0, 1'b1, 1'b1, 1'b1, 12'd4, 1'b0);
        send(4'hF, 4'h1, 1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0);
        send(4'h7, 4'h7, 1'b1, 1'b1, 1'b1, 1'b1, 12'd49, 1'b0);
        idle(3);

        // Unsigned overflow: 19 x 225 = 4275 -> 179, then a clean group right after
        for (int i = 0; i < 19; i++) begin
            send(4'hF, 4'hF, 1'b0, i == 0, i == 18, i == 18, 12'd179, 1'b1);
        end
        send(4'h1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1, 12'd1, 1'b0);
        idle(3);

        // Signed overflow: 32 x 64 wraps to 0x800; 31 x 64 = 1984 fits
        for (int i = 0; i < 32; i++) begin
            send(4'h8, 4'h8, 1'b1, i == 0, i == 31, i == 31, 12'h800, 1'b1);
        end
        for (int i = 0; i < 31; i++) begin
            send(4'h8, 4'h8, 1'b1, i == 0, i == 30, i == 30, 12'd1984, 1'b0);
        end
        idle(3);

        // Reset while the last element sits in S2; an element offered with reset is dropped
        send(4'h1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
        send(4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
        send(4'h1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 1'b0);
        @(negedge clk);
        bus.arg_vld = 1'b0;
        @(negedge clk);
        rst            = 1'b1;
        bus.arg_vld    = 1'b1;
        bus.a          = 4'h5;
        bus.b          = 4'h5;
        bus.signed_mul = 1'b0;
        bus.first      = 1'b1;
        bus.last       = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        bus.arg_vld = 1'b0;
        #1;
        chk("midreset_res_vld", int'(bus.res_vld), 0);
        chk("midreset_res", int'(bus.res), 0);
        chk("midreset_ovf", int'(bus.ovf), 0);
        idle(3);

        // Fresh group after reset, then a first-less element continues from acc
        send(4'h2, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 12'd6, 1'b0);
        send(4'h1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 12'd7, 1'b0);
        idle(6);

        chk("results_outstanding", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
